// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// EX-stage execution unit for the multicycle MIPS CPU. Decodes ALUop/funct
// into a 4-bit operation code and executes it. Simple integer operations
// finish at the accept edge. Multiply and divide run for WIDTH cycles on
// magnitudes and update the architectural HI/LO registers.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   operation request present
//   in_ready   unit can accept a request (state is IDLE)
//   ALUop      00 add, 01 sub, 10 decode funct, 11 add
//   funct      R-type function field
//   a, b       operands (rs, rt/immediate)
//   m          combinational decode of ALUop/funct
//   out_valid  one-cycle pulse, result is valid
//   result     registered result
//   zero       registered (result == 0)
//   busy       multiply/divide iteration in progress
//   hi, lo     architectural HI/LO registers
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       m,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_count;
  logic [WIDTH-1:0]     r_result;
  logic                 r_zero;
  logic                 r_outValid;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  // Multiply: running product. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opA;
  logic [WIDTH-1:0]     r_opB;
  logic                 r_negA;
  logic                 r_negB;
  logic                 r_bZero;
  logic [WIDTH-1:0]     r_aRaw;

  logic [3:0]           w_code;
  logic [WIDTH-1:0]     w_alu;
  logic                 w_accept;
  logic                 w_isMul;
  logic                 w_isDiv;
  logic                 w_signedOp;
  logic                 w_aNeg;
  logic                 w_bNeg;
  logic [WIDTH-1:0]     w_aMag;
  logic [WIDTH-1:0]     w_bMag;
  logic [2*WIDTH-1:0]   w_mulAcc;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH:0]       w_remShift;
  logic                 w_remFits;
  logic [WIDTH-1:0]     w_remNext;
  logic [WIDTH-1:0]     w_quoNext;
  logic [WIDTH-1:0]     w_divLo;
  logic [WIDTH-1:0]     w_divHi;

  // Operation decode; unknown funct values fall back to ADD.
  always_comb begin
    w_code = OP_ADD;
    case (ALUop)
      2'b01: w_code = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: w_code = OP_ADD;
          6'b100010, 6'b100011: w_code = OP_SUB;
          6'b100100: w_code = OP_AND;
          6'b100101: w_code = OP_OR;
          6'b100110: w_code = OP_XOR;
          6'b100111: w_code = OP_NOR;
          6'b101010: w_code = OP_SLT;
          6'b101011: w_code = OP_SLTU;
          6'b011000: w_code = OP_MULT;
          6'b011001: w_code = OP_MULTU;
          6'b011010: w_code = OP_DIV;
          6'b011011: w_code = OP_DIVU;
          6'b010000: w_code = OP_MFHI;
          6'b010010: w_code = OP_MFLO;
          default:   w_code = OP_ADD;
        endcase
      end
      default: w_code = OP_ADD;
    endcase
  end

  // Single-cycle datapath, evaluated on the live operands.
  always_comb begin
    w_alu = '0;
    case (w_code)
      OP_ADD:  w_alu = a + b;
      OP_SUB:  w_alu = a - b;
      OP_AND:  w_alu = a & b;
      OP_OR:   w_alu = a | b;
      OP_XOR:  w_alu = a ^ b;
      OP_NOR:  w_alu = ~(a | b);
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_isMul    = (w_code == OP_MULT) || (w_code == OP_MULTU);
  assign w_isDiv    = (w_code == OP_DIV)  || (w_code == OP_DIVU);
  assign w_signedOp = (w_code == OP_MULT) || (w_code == OP_DIV);
  assign w_aNeg     = w_signedOp && a[WIDTH-1];
  assign w_bNeg     = w_signedOp && b[WIDTH-1];
  assign w_aMag     = w_aNeg ? -a : a;
  assign w_bMag     = w_bNeg ? -b : b;

  // Multiply step: walk the multiplier from its MSB, shift then add.
  assign w_mulAcc = {r_acc[2*WIDTH-2:0], 1'b0}
                  + (r_opB[r_count] ? {{WIDTH{1'b0}}, r_opA} : {(2*WIDTH){1'b0}});
  assign w_prod   = (r_negA ^ r_negB) ? -w_mulAcc : w_mulAcc;

  // Restoring divide step: bring in the next dividend bit, subtract if it fits.
  // The remainder stays below the divisor, so the W-bit difference is exact.
  assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_opA[r_count]};
  assign w_remFits  = (w_remShift >= {1'b0, r_opB});
  assign w_remNext  = w_remFits ? (w_remShift[WIDTH-1:0] - r_opB) : w_remShift[WIDTH-1:0];
  assign w_quoNext  = {r_acc[WIDTH-2:0], w_remFits};

  // Sign fix-up of the final step; divide by zero overrides the datapath.
  always_comb begin
    w_divLo = (r_negA ^ r_negB) ? -w_quoNext : w_quoNext;
    w_divHi = r_negA ? -w_remNext : w_remNext;
    if (r_bZero) begin
      w_divLo = '1;
      w_divHi = r_aRaw;
    end
  end

  // Control FSM and all architectural state. out_valid defaults low and is
  // raised only by a single-cycle accept or a mul/div completion edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_outValid <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_acc      <= '0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_negA     <= 1'b0;
      r_negB     <= 1'b0;
      r_bZero    <= 1'b0;
      r_aRaw     <= '0;
    end else begin
      r_outValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_isMul || w_isDiv) begin
              r_state <= w_isMul ? MUL : DIV;
              r_count <= CW'(WIDTH-1);
              r_acc   <= '0;
              r_opA   <= w_aMag;
              r_opB   <= w_bMag;
              r_negA  <= w_aNeg;
              r_negB  <= w_bNeg;
              r_bZero <= (b == '0);
              r_aRaw  <= a;
            end else begin
              r_result   <= w_alu;
              r_zero     <= (w_alu == '0);
              r_outValid <= 1'b1;
            end
          end
        end
        MUL: begin
          r_acc <= w_mulAcc;
          if (r_count == '0) begin
            r_state    <= IDLE;
            r_hi       <= w_prod[2*WIDTH-1:WIDTH];
            r_lo       <= w_prod[WIDTH-1:0];
            r_result   <= w_prod[WIDTH-1:0];
            r_zero     <= (w_prod[WIDTH-1:0] == '0);
            r_outValid <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        DIV: begin
          r_acc <= {w_remNext, w_quoNext};
          if (r_count == '0) begin
            r_state    <= IDLE;
            r_hi       <= w_divHi;
            r_lo       <= w_divLo;
            r_result   <= w_divLo;
            r_zero     <= (w_divLo == '0);
            r_outValid <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign m         = w_code;
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_outValid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed bench for alu_exec_unit at WIDTH=32. Inputs change 1 time unit
// after a rising edge and outputs are checked at that same point, well away
// from the next active edge.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       ALUop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       m;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int nCompared = 0;
  int nMismatch = 0;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUop     (ALUop),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .m         (m),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Hard upper bound on run time in case the design locks up.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one request onto the input side without waiting.
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] fn,
                               input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    in_valid = v;
    ALUop    = op;
    funct    = fn;
    a        = va;
    b        = vb;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until in_ready returns, counting not-ready cycles and any stray
  // out_valid or busy-low samples along the way.
  task automatic waitIdle(output int cycles, output int strayValid, output int busyLow);
    cycles     = 0;
    strayValid = 0;
    busyLow    = 0;
    while (!in_ready && cycles < 200) begin
      if (out_valid) strayValid++;
      if (!busy) busyLow++;
      cycles++;
      tick();
    end
  endtask

  logic [5:0] fList [17];
  logic [3:0] mList [17];
  int cycles;
  int stray;
  int busyLow;

  initial begin
    fList = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
              6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b011000, 6'b011001,
              6'b011010, 6'b011011, 6'b010000, 6'b010010, 6'b111111};
    mList = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
              4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'h0};

    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    #2;
    checkOutput("rst_result", result, 0);
    checkOutput("rst_zero", zero, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    rst = 1'b0;

    // Decode table, combinational and independent of the handshake.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 2'b10, fList[i], '0, '0);
      #1;
      checkOutput($sformatf("decode_f%02h", fList[i]), m, mList[i]);
    end
    applyStimulus(1'b0, 2'b00, 6'b100010, '0, '0);
    #1 checkOutput("decode_op00", m, 4'h0);
    applyStimulus(1'b0, 2'b01, 6'b100100, '0, '0);
    #1 checkOutput("decode_op01", m, 4'h1);
    applyStimulus(1'b0, 2'b11, 6'b100010, '0, '0);
    #1 checkOutput("decode_op11", m, 4'h0);

    tick();

    // SUB 5-5: zero result, pulse one cycle after accept.
    applyStimulus(1'b1, 2'b01, 6'b0, 32'd5, 32'd5);
    tick();
    checkOutput("sub_valid", out_valid, 1);
    checkOutput("sub_result", result, 0);
    checkOutput("sub_zero", zero, 1);
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    tick();
    checkOutput("sub_valid_drop", out_valid, 0);

    applyStimulus(1'b1, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1);
    tick();
    checkOutput("slt_result", result, 1);
    checkOutput("slt_zero", zero, 0);
    applyStimulus(1'b1, 2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1);
    tick();
    checkOutput("sltu_result", result, 0);
    checkOutput("sltu_zero", zero, 1);
    applyStimulus(1'b1, 2'b10, 6'b100111, 32'h0, 32'h0);
    tick();
    checkOutput("nor_result", result, 32'hFFFFFFFF);
    applyStimulus(1'b1, 2'b10, 6'b100110, 32'hF0F0_1234, 32'h0FF0_1234);
    tick();
    checkOutput("xor_result", result, 32'hFF00_0000);

    // Four back-to-back accepts: AND, OR, ADD, SUB.
    applyStimulus(1'b1, 2'b10, 6'b100100, 32'h0000_FF0F, 32'h0000_0FF0);
    tick();
    checkOutput("b2b0_valid", out_valid, 1);
    checkOutput("b2b0_result", result, 32'h0000_0F00);
    applyStimulus(1'b1, 2'b10, 6'b100101, 32'h1200_0000, 32'h0000_0034);
    tick();
    checkOutput("b2b1_valid", out_valid, 1);
    checkOutput("b2b1_result", result, 32'h1200_0034);
    applyStimulus(1'b1, 2'b00, 6'b0, 32'hFFFFFFFF, 32'd2);
    tick();
    checkOutput("b2b2_valid", out_valid, 1);
    checkOutput("b2b2_result", result, 32'd1);
    applyStimulus(1'b1, 2'b01, 6'b0, 32'd0, 32'd1);
    tick();
    checkOutput("b2b3_valid", out_valid, 1);
    checkOutput("b2b3_result", result, 32'hFFFFFFFF);
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    tick();
    checkOutput("b2b_idle_valid", out_valid, 0);

    // MULT -2 * 3.
    applyStimulus(1'b1, 2'b10, 6'b011000, 32'hFFFFFFFE, 32'd3);
    tick();
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    waitIdle(cycles, stray, busyLow);
    checkOutput("mult_notready_cycles", cycles, 32);
    checkOutput("mult_stray_valid", stray, 0);
    checkOutput("mult_busy_low", busyLow, 0);
    checkOutput("mult_valid", out_valid, 1);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFFA);
    checkOutput("mult_result", result, 32'hFFFFFFFA);
    checkOutput("mult_busy_done", busy, 0);
    applyStimulus(1'b1, 2'b10, 6'b010000, '0, '0);
    tick();
    checkOutput("mfhi_valid", out_valid, 1);
    checkOutput("mfhi_result", result, 32'hFFFFFFFF);
    applyStimulus(1'b1, 2'b10, 6'b010010, '0, '0);
    tick();
    checkOutput("mflo_result", result, 32'hFFFFFFFA);
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    tick();

    // DIV -7 / 2: quotient -3, remainder -1.
    applyStimulus(1'b1, 2'b10, 6'b011010, 32'hFFFFFFF9, 32'd2);
    tick();
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    waitIdle(cycles, stray, busyLow);
    checkOutput("div_cycles", cycles, 32);
    checkOutput("div_valid", out_valid, 1);
    checkOutput("div_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_hi", hi, 32'hFFFFFFFF);
    checkOutput("div_result", result, 32'hFFFFFFFD);

    // DIVU 7 / 0.
    applyStimulus(1'b1, 2'b10, 6'b011011, 32'd7, 32'd0);
    tick();
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    waitIdle(cycles, stray, busyLow);
    checkOutput("divu0_cycles", cycles, 32);
    checkOutput("divu0_lo", lo, 32'hFFFFFFFF);
    checkOutput("divu0_hi", hi, 32'd7);

    // DIV most-negative / -1.
    applyStimulus(1'b1, 2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF);
    tick();
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    waitIdle(cycles, stray, busyLow);
    checkOutput("divmn_lo", lo, 32'h80000000);
    checkOutput("divmn_hi", hi, 32'h0);
    checkOutput("divmn_zero", zero, 0);

    // DIVU 100 / 7: plain unsigned quotient and remainder.
    applyStimulus(1'b1, 2'b10, 6'b011011, 32'd100, 32'd7);
    tick();
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    waitIdle(cycles, stray, busyLow);
    checkOutput("divu_lo", lo, 32'd14);
    checkOutput("divu_hi", hi, 32'd2);

    // MULTU 0x10000 * 0x10000 with a following ADD held on the input.
    applyStimulus(1'b1, 2'b10, 6'b011001, 32'h0001_0000, 32'h0001_0000);
    tick();
    applyStimulus(1'b1, 2'b00, 6'b0, 32'd10, 32'd20);
    waitIdle(cycles, stray, busyLow);
    checkOutput("multu_held_cycles", cycles, 32);
    checkOutput("multu_held_stray", stray, 0);
    checkOutput("multu_valid", out_valid, 1);
    checkOutput("multu_hi", hi, 32'd1);
    checkOutput("multu_lo", lo, 32'd0);
    checkOutput("multu_zero", zero, 1);
    tick();
    checkOutput("held_add_valid", out_valid, 1);
    checkOutput("held_add_result", result, 32'd30);
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    tick();

    // Reset during iteration 10 of a DIV.
    applyStimulus(1'b1, 2'b10, 6'b011010, 32'd100, 32'd7);
    tick();
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("rstmid_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstmid_hi", hi, 0);
    checkOutput("rstmid_lo", lo, 0);
    checkOutput("rstmid_ready", in_ready, 1);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_valid", out_valid, 0);
    #1 rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) stray++;
    end
    checkOutput("rstmid_no_late_valid", stray, 0);
    applyStimulus(1'b1, 2'b00, 6'b0, 32'd1, 32'd2);
    tick();
    checkOutput("post_rst_add_valid", out_valid, 1);
    checkOutput("post_rst_add_result", result, 32'd3);
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the single-cycle ALU control decoder: decodes ALUop/funct into an extended 4-bit operation code and executes the operation.
- Covers the full MIPS R-type integer set, including iterative mult/multu/div/divu with architectural HI/LO registers.
- Sits in the EX stage of the multicycle CPU.
- Uses a valid/ready handshake on input and a one-cycle out_valid pulse on output, so the control FSM can stall on long operations.

Parameters:
- WIDTH, 32: operand, result, HI and LO width; must be ≥4 and even.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request present
- in_ready  out  1  unit can accept; equals (state==IDLE)
- ALUop  in  2  00 add, 01 sub, 10 decode funct, 11 add
- funct  in  6  R-type function field
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt or immediate)
- m  out  4  combinational decode of the current ALUop/funct, independent of handshake
- out_valid  out  1  result valid, one-cycle pulse
- result  out  WIDTH  registered result
- zero  out  1  registered (result==0), updated together with result
- busy  out  1  mul/div iteration in progress
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Decode of m:
  - ALUop 00 → 0000 ADD; 01 → 0001 SUB; 11 → 0000 ADD.
  - ALUop 10, funct → code:
    - 100000/100001 → 0000 ADD; 100010/100011 → 0001 SUB
    - 100100 → 0010 AND; 100101 → 0011 OR; 100110 → 0100 XOR; 100111 → 0101 NOR
    - 101010 → 0110 SLT; 101011 → 0111 SLTU
    - 011000 → 1000 MULT; 011001 → 1001 MULTU; 011010 → 1010 DIV; 011011 → 1011 DIVU
    - 010000 → 1100 MFHI; 010010 → 1101 MFLO
    - any other funct → 0000 ADD.
- Accept:
  - Transfer occurs on a rising edge with in_valid && in_ready.
  - Inputs are sampled only at that edge.
- Single-cycle ops (codes 0000–0111, 1100, 1101):
  - result, zero and out_valid are registered at the accept edge; out_valid is high for exactly the following cycle.
  - Back-to-back accepts are allowed every cycle.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLT is a signed compare, SLTU unsigned; result is {WIDTH-1 zeros, flag}.
  - MFHI/MFLO return the current hi/lo.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL on accept of code 1000/1001; IDLE → DIV on accept of 1010/1011.
  - Both long states run a counter from WIDTH-1 down to 0, one step per cycle.
  - Return to IDLE at the edge where the counter hits 0, i.e. WIDTH edges after accept.
  - busy = (state != IDLE).
- MUL:
  - Shift-add on operand magnitudes; signed variant negates the 2·WIDTH product if sign(a)^sign(b).
  - {hi, lo} ← product.
- DIV:
  - Restoring divide on magnitudes; lo ← quotient, hi ← remainder.
  - Signed variant: quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - Most-negative ÷ −1 → lo = most-negative, hi = 0.
  - b == 0 (either variant) → lo = all ones, hi = a; still takes WIDTH cycles.
- Completion of mul/div:
  - hi/lo are written at the final edge.
  - out_valid pulses for the following cycle with result = lo and zero = (lo==0).
  - in_ready returns high in that same cycle, so an MFHI accepted then sees the new hi.
- Otherwise hi/lo hold; only mul/div completion writes them.
- out_valid is low on every cycle not immediately following an accept-edge result or a completion edge.
- in_valid while busy is ignored (no accept); the request must be held by the master until accepted.
- Reset (asynchronous, any time, including mid-iteration):
  - state=IDLE, counter=0; result, hi, lo = 0; zero=1, out_valid=0, busy=0.
  - Any in-flight operation is discarded with no out_valid.

Test Plan:
- All decodes: sweep ALUop=10 over every listed funct plus 111111, and ALUop 00/01/11 → m matches table; 111111 and ALUop 11 → 0000.
- Single-cycle ops (WIDTH=32):
  - SUB with a=5, b=5 → result 0, zero=1, out_valid one cycle after accept.
  - SLT with a=0xFFFFFFFF, b=1 → 1; SLTU with the same operands → 0.
  - NOR with a=0, b=0 → 0xFFFFFFFF.
  - Four back-to-back accepts → four consecutive out_valid pulses.
- MULT with a=0xFFFFFFFE (−2), b=3:
  - in_ready low for exactly 32 cycles; busy high throughout.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA; out_valid pulse with result=lo.
  - MFHI issued on the first ready cycle → 0xFFFFFFFF.
- Divides:
  - DIV with a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU with a=7, b=0 → lo=0xFFFFFFFF, hi=7.
  - DIV with a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- in_valid held high during MULTU → no second accept until ready; held op accepted on the completion cycle.
- Assert rst at iteration 10 of DIV:
  - Immediately hi=lo=0, in_ready=1, no out_valid.
  - A subsequent ADD with a=1, b=2 → result 3.
